fifo_access_ctrl: RTL and testbench

Controller and arbiter in front of the 48-entry key-XOR FIFO buffer. It shares the FIFO's single command port between two write requesters and one read requester using round-robin. It keeps a shadow occupancy count and flushes the FIFO after reset. It sequences cipher-key changes so the key only changes when the FIFO is empty; every resident word is written and read under the same key.

---
 rtl/fifo_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter3.sv | 42 ++++
 rtl/fifo_access_ctrl.sv | 136 +++++++++++++
 tb/tb_fifo_access_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the key-XOR FIFO access controller.
// Requester indices double as bit positions in the arbiter grant vector.
package fifo_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 48;
    localparam int CNT_W_DEF  = 6;

    localparam int REQ_WR0 = 0;
    localparam int REQ_WR1 = 1;
    localparam int REQ_RD  = 2;

    typedef enum logic [1:0] {
        FLUSH,
        RUN,
        KEY_DRAIN
    } state_t;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter with a registered priority pointer.
// The pointer moves to the requester just after the one granted.
module rr_arbiter3 (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] grant
);

    logic [1:0] ptr;

    always_comb begin
        grant = 3'b000;
        case (ptr)
            2'd1:
                grant = req[1] ? 3'b010 :
                        req[2] ? 3'b100 :
                        req[0] ? 3'b001 : 3'b000;
            2'd2:
                grant = req[2] ? 3'b100 :
                        req[0] ? 3'b001 :
                        req[1] ? 3'b010 : 3'b000;
            default:
                grant = req[0] ? 3'b001 :
                        req[1] ? 3'b010 :
                        req[2] ? 3'b100 : 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 2'd0;
        end else if (grant[0]) begin
            ptr <= 2'd1;
        end else if (grant[1]) begin
            ptr <= 2'd2;
        end else if (grant[2]) begin
            ptr <= 2'd0;
        end
    end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Arbitrated command front-end for the key-XOR FIFO: shadow occupancy,
// post-reset flush and drain-before-swap cipher key sequencing.
module fifo_access_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                DEPTH     = DEPTH_DEF,
    parameter int                CNT_W     = CNT_W_DEF,
    parameter logic [DATA_W-1:0] KEY_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr0_valid,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              key_load,
    input  logic [DATA_W-1:0] key_in,
    output logic              key_busy,
    output logic              fifo_cen,
    output logic              fifo_reset,
    output logic              fifo_rw,
    output logic [DATA_W-1:0] fifo_data_in,
    output logic [DATA_W-1:0] fifo_key,
    input  logic [DATA_W-1:0] fifo_data_out,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic              fifo_last,
    output logic [CNT_W-1:0]  occ,
    output logic              sync_err
);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        req;
    logic [2:0]        grant;
    logic              wr_ok;
    logic              rd_ok;
    logic              wr_grant;
    logic              swap;
    logic              mismatch;
    logic              rd_pend;
    logic [DATA_W-1:0] key_pend;
    logic              unused_last;

    assign unused_last = fifo_last;

    assign wr_ok = (state == RUN) && (occ < CNT_W'(DEPTH));
    assign rd_ok = (state != FLUSH) && (occ != '0);

    assign req[REQ_WR0] = wr0_valid && wr_ok;
    assign req[REQ_WR1] = wr1_valid && wr_ok;
    assign req[REQ_RD]  = rd_req && rd_ok;

    rr_arbiter3 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    assign wr0_ready = grant[REQ_WR0];
    assign wr1_ready = grant[REQ_WR1];
    assign wr_grant  = grant[REQ_WR0] | grant[REQ_WR1];
    assign rd_data   = fifo_data_out;

    // Status is only trustworthy once the last registered command has executed.
    assign mismatch = (fifo_empty != (occ == '0)) ||
                      (fifo_full != (occ == CNT_W'(DEPTH)));

    always_comb begin
        state_nxt = state;
        case (state)
            FLUSH:
                state_nxt = RUN;
            RUN:
                if (key_load) state_nxt = KEY_DRAIN;
            KEY_DRAIN:
                if (!key_load && occ == '0 && !fifo_cen) state_nxt = RUN;
            default:
                state_nxt = FLUSH;
        endcase
    end

    assign swap = (state == KEY_DRAIN) && (state_nxt == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FLUSH;
            fifo_cen     <= 1'b1;
            fifo_reset   <= 1'b1;
            fifo_rw      <= 1'b0;
            fifo_data_in <= '0;
            fifo_key     <= KEY_RESET;
            key_pend     <= KEY_RESET;
            key_busy     <= 1'b0;
            occ          <= '0;
            rd_pend      <= 1'b0;
            rd_valid     <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            fifo_reset <= 1'b0;
            fifo_cen   <= |grant;
            fifo_rw    <= wr_grant;
            if (grant[REQ_WR0]) begin
                fifo_data_in <= wr0_data;
            end else if (grant[REQ_WR1]) begin
                fifo_data_in <= wr1_data;
            end
            if (wr_grant) begin
                occ <= occ + CNT_W'(1);
            end else if (grant[REQ_RD]) begin
                occ <= occ - CNT_W'(1);
            end
            rd_pend  <= grant[REQ_RD];
            rd_valid <= rd_pend;
            if (key_load && state != FLUSH) begin
                key_pend <= key_in;
                key_busy <= 1'b1;
            end else if (swap) begin
                fifo_key <= key_pend;
                key_busy <= 1'b0;
            end
            if (state != FLUSH && !fifo_cen && mismatch) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: behavioural key-XOR FIFO plus a read-data
// scoreboard fed with the words each scenario expects to read back.
module tb_fifo_access_ctrl;

    logic        clk;
    logic        reset;
    logic        wr0_valid;
    logic [31:0] wr0_data;
    logic        wr0_ready;
    logic        wr1_valid;
    logic [31:0] wr1_data;
    logic        wr1_ready;
    logic        rd_req;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        key_load;
    logic [31:0] key_in;
    logic        key_busy;
    logic        fifo_cen;
    logic        fifo_reset;
    logic        fifo_rw;
    logic [31:0] fifo_data_in;
    logic [31:0] fifo_key;
    logic [31:0] fifo_data_out;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_last;
    logic [5:0]  occ;
    logic        sync_err;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    fifo_access_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .wr0_valid     (wr0_valid),
        .wr0_data      (wr0_data),
        .wr0_ready     (wr0_ready),
        .wr1_valid     (wr1_valid),
        .wr1_data      (wr1_data),
        .wr1_ready     (wr1_ready),
        .rd_req        (rd_req),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .key_load      (key_load),
        .key_in        (key_in),
        .key_busy      (key_busy),
        .fifo_cen      (fifo_cen),
        .fifo_reset    (fifo_reset),
        .fifo_rw       (fifo_rw),
        .fifo_data_in  (fifo_data_in),
        .fifo_key      (fifo_key),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_last     (fifo_last),
        .occ           (occ),
        .sync_err      (sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural FIFO: words are stored XORed with the key and unmasked on read.
    logic [31:0] fmem [0:47];
    logic [5:0]  fwp;
    logic [5:0]  frp;
    logic [6:0]  fcnt;

    assign fifo_empty = (fcnt == 7'd0);
    assign fifo_full  = (fcnt == 7'd48);
    assign fifo_last  = (fcnt == 7'd1);

    always @(posedge clk) begin
        if (fifo_reset) begin
            fwp  <= 6'd0;
            frp  <= 6'd0;
            fcnt <= 7'd0;
        end else if (fifo_cen) begin
            if (fifo_rw) begin
                if (fcnt < 7'd48) begin
                    fmem[fwp] <= fifo_data_in ^ fifo_key;
                    fwp  <= (fwp == 6'd47) ? 6'd0 : fwp + 6'd1;
                    fcnt <= fcnt + 7'd1;
                end
            end else if (fcnt != 7'd0) begin
                fifo_data_out <= fmem[frp] ^ fifo_key;
                frp  <= (frp == 6'd47) ? 6'd0 : frp + 6'd1;
                fcnt <= fcnt - 7'd1;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && rd_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: got %h, none expected", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    miscompares++;
                    $display("FAIL rd_data: got %h, want %h", rd_data, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    task automatic write_words(input bit port, input int n,
                               input logic [31:0] base, input bit push);
        int  done = 0;
        int  t = 0;
        bit  g;
        @(negedge clk);
        if (port) begin
            wr1_valid = 1'b1;
            wr1_data  = base;
        end else begin
            wr0_valid = 1'b1;
            wr0_data  = base;
        end
        while (done < n && t < 200) begin
            #1;
            g = port ? wr1_ready : wr0_ready;
            @(negedge clk);
            t++;
            if (g) begin
                if (push) exp_q.push_back(base + done);
                done++;
                if (port) wr1_data = base + done;
                else      wr0_data = base + done;
            end
            if (done == n) begin
                wr0_valid = 1'b0;
                wr1_valid = 1'b0;
            end
        end
        vectors++;
        if (done != n) begin
            miscompares++;
            $display("FAIL write_timeout: wrote %0d, want %0d", done, n);
        end
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({fifo_cen, fifo_reset, fifo_rw, rd_valid, key_busy, sync_err} !== 6'b110000
            || occ !== 6'd0 || fifo_data_in !== 32'h0 || fifo_key !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_values: cen/rst/rw/rv/kb/se=%b occ=%0d din=%h key=%h, want 110000 0 0 0",
                     {fifo_cen, fifo_reset, fifo_rw, rd_valid, key_busy, sync_err},
                     occ, fifo_data_in, fifo_key);
        end
        @(negedge clk);
        reset = 1'b0;
        wr0_valid = 1'b1;
        wr0_data = 32'hBAD0BAD0;
        #1;
        vectors++;
        if ({wr0_ready, fifo_cen, fifo_reset} !== 3'b011) begin
            miscompares++;
            $display("FAIL flush_cycle: ready/cen/rst=%b, want 011",
                     {wr0_ready, fifo_cen, fifo_reset});
        end
        @(negedge clk);
        vectors++;
        if ({fifo_cen, fifo_reset} !== 2'b00 || occ !== 6'd0) begin
            miscompares++;
            $display("FAIL run_entry: cen/rst=%b occ=%0d, want 00 0",
                     {fifo_cen, fifo_reset}, occ);
        end
        wr0_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (sync_err !== 1'b0 || fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL post_flush: sync_err=%b empty=%b, want 0 1", sync_err, fifo_empty);
        end
    endtask

    task automatic test_interleave();
        bit   g0;
        bit   g1;
        int   n0 = 0;
        int   n1 = 0;
        int   bad = 0;
        logic [11:0] pat = '0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h11000000 + i);
            exp_q.push_back(32'h22000000 + i);
        end
        @(negedge clk);
        wr0_valid = 1'b1;
        wr0_data  = 32'h11000000;
        wr1_valid = 1'b1;
        wr1_data  = 32'h22000000;
        for (int k = 0; k < 8; k++) begin
            #1;
            g0 = wr0_ready;
            g1 = wr1_ready;
            if ({g0, g1} != (((k % 2) == 0) ? 2'b10 : 2'b01)) bad++;
            @(negedge clk);
            if (g0) begin
                n0++;
                if (n0 == 4) wr0_valid = 1'b0;
                else wr0_data = 32'h11000000 + n0;
            end
            if (g1) begin
                n1++;
                if (n1 == 4) wr1_valid = 1'b0;
                else wr1_data = 32'h22000000 + n1;
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rr_alternate: %0d cycles off pattern, want 0", bad);
        end
        vectors++;
        if (occ !== 6'd8) begin
            miscompares++;
            $display("FAIL occ_after_8: got %0d, want 8", occ);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            pat[c] = rd_valid;
            if (c == 0) rd_req = 1'b1;
            if (c == 8) rd_req = 1'b0;
        end
        vectors++;
        if (pat !== 12'b001111111100) begin
            miscompares++;
            $display("FAIL rd_latency: pulses %b, want 001111111100", pat);
        end
        vectors++;
        if (exp_q.size() != 0 || occ !== 6'd0) begin
            miscompares++;
            $display("FAIL interleave_drain: left %0d occ=%0d, want 0 0", exp_q.size(), occ);
        end
    endtask

    task automatic test_full();
        bit g;
        int n = 0;
        int blk = 0;
        for (int i = 0; i < 48; i++) exp_q.push_back(32'h30000000 + i);
        @(negedge clk);
        wr0_valid = 1'b1;
        wr0_data  = 32'h30000000;
        for (int c = 0; c < 52; c++) begin
            #1;
            g = wr0_ready;
            if (g && occ >= 6'd48) blk++;
            @(negedge clk);
            if (g) begin
                n++;
                wr0_data = 32'h30000000 + n;
            end
        end
        vectors++;
        if (n != 48 || blk != 0) begin
            miscompares++;
            $display("FAIL fill: grants %0d ready_at_full %0d, want 48 0", n, blk);
        end
        vectors++;
        if (occ !== 6'd48 || fifo_full !== 1'b1 || sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_state: occ=%0d full=%b se=%b, want 48 1 0", occ, fifo_full, sync_err);
        end
        rd_req = 1'b1;
        #1;
        vectors++;
        if (wr0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_blocks: ready=%b, want 0", wr0_ready);
        end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        vectors++;
        if (wr0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_returns: ready=%b, want 1", wr0_ready);
        end
        exp_q.push_back(32'h30000030);
        @(negedge clk);
        wr0_valid = 1'b0;
        rd_req = 1'b1;
        repeat (52) @(negedge clk);
        rd_req = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0 || occ !== 6'd0 || fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL full_drain: left %0d occ=%0d empty=%b, want 0 0 1",
                     exp_q.size(), occ, fifo_empty);
        end
    endtask

    task automatic test_key_change();
        int blk = 0;
        logic [1:0] kb;
        write_words(1'b1, 3, 32'h40000000, 1'b1);
        key_load = 1'b1;
        key_in   = 32'hA5A5A5A5;
        rd_req   = 1'b1;
        @(negedge clk);
        key_load  = 1'b0;
        key_in    = 32'h0;
        wr0_valid = 1'b1;
        wr0_data  = 32'hDEADBEEF;
        vectors++;
        if (key_busy !== 1'b1 || fifo_key !== 32'h0) begin
            miscompares++;
            $display("FAIL key_pending: busy=%b key=%h, want 1 00000000", key_busy, fifo_key);
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            if (wr0_ready !== 1'b0) blk++;
            @(negedge clk);
        end
        wr0_valid = 1'b0;
        vectors++;
        if (blk != 0) begin
            miscompares++;
            $display("FAIL drain_blocks_wr: %0d grants, want 0", blk);
        end
        kb = {key_busy, (fifo_key == 32'h0)};
        @(negedge clk);
        vectors++;
        if (kb !== 2'b11 || key_busy !== 1'b0 || fifo_key !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL key_swap: before=%b after busy=%b key=%h, want 11 0 a5a5a5a5",
                     kb, key_busy, fifo_key);
        end
        wr0_valid = 1'b1;
        wr0_data  = 32'h12345678;
        #1;
        vectors++;
        if (wr0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_swap_write: ready=%b, want 1", wr0_ready);
        end
        exp_q.push_back(32'h12345678);
        @(negedge clk);
        wr0_valid = 1'b0;
        repeat (5) @(negedge clk);
        rd_req = 1'b0;
        vectors++;
        if (exp_q.size() != 0 || occ !== 6'd0) begin
            miscompares++;
            $display("FAIL key_readback: left %0d occ=%0d, want 0 0", exp_q.size(), occ);
        end
    endtask

    task automatic test_empty_read();
        int bad = 0;
        @(negedge clk);
        rd_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (fifo_cen !== 1'b0 || rd_valid !== 1'b0) bad++;
        end
        rd_req = 1'b0;
        vectors++;
        if (bad != 0 || occ !== 6'd0) begin
            miscompares++;
            $display("FAIL empty_read: %0d active cycles occ=%0d, want 0 0", bad, occ);
        end
    endtask

    task automatic test_reset_mid();
        write_words(1'b0, 10, 32'h50000000, 1'b0);
        rd_req   = 1'b1;
        key_load = 1'b1;
        key_in   = 32'h5A5A5A5A;
        @(negedge clk);
        rd_req   = 1'b0;
        key_load = 1'b0;
        vectors++;
        if (key_busy !== 1'b1 || occ !== 6'd9) begin
            miscompares++;
            $display("FAIL pre_reset: busy=%b occ=%0d, want 1 9", key_busy, occ);
        end
        reset = 1'b1;
        exp_q.delete();
        #1;
        vectors++;
        if ({fifo_cen, fifo_reset, fifo_rw, rd_valid, key_busy} !== 5'b11000
            || occ !== 6'd0 || fifo_key !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: cen/rst/rw/rv/kb=%b occ=%0d key=%h, want 11000 0 0",
                     {fifo_cen, fifo_reset, fifo_rw, rd_valid, key_busy}, occ, fifo_key);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (occ !== 6'd0 || fifo_empty !== 1'b1 || sync_err !== 1'b0
            || key_busy !== 1'b0 || fifo_key !== 32'h0) begin
            miscompares++;
            $display("FAIL after_flush: occ=%0d empty=%b se=%b busy=%b key=%h, want 0 1 0 0 0",
                     occ, fifo_empty, sync_err, key_busy, fifo_key);
        end
        write_words(1'b1, 1, 32'h77000000, 1'b1);
        rd_req = 1'b1;
        repeat (4) @(negedge clk);
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0 || sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_rw: left %0d se=%b, want 0 0", exp_q.size(), sync_err);
        end
    endtask

    initial begin
        reset     = 1'b1;
        wr0_valid = 1'b0;
        wr0_data  = '0;
        wr1_valid = 1'b0;
        wr1_data  = '0;
        rd_req    = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        test_reset();
        test_interleave();
        test_full();
        test_key_change();
        test_empty_read();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
